wb_commit: RTL and testbench

// - Writeback producer for the scoreboarded register file: collects results from SALU and LSU,

---
 rtl/wb_commit_pkg.sv | 14 +
 rtl/wb_commit_if.sv | 28 ++
 rtl/wb_commit_fifo.sv | 86 ++++++++
 rtl/wb_commit.sv | 87 ++++++++
 tb/tb_wb_commit.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/wb_commit_pkg.sv
// Shared sizing constants and small helpers for the writeback commit path.
// Imported by the interface, the result FIFO and the commit top.
package wb_commit_pkg;

    localparam int unsigned WB_DEPTH  = 32'd4;
    localparam int unsigned REG_IDX_W = 32'd5;
    localparam int unsigned XLEN      = 32'd32;

    // Both sources may enqueue together, so a source is ready only with two free slots.
    function automatic logic has_two_free(input int unsigned depth, input int unsigned cnt);
        return ((depth - cnt) >= 32'd2);
    endfunction

endpackage

// File: rtl/wb_commit_if.sv
// Result/commit bus between the execute units, wb_commit and the register file.
// The slave modport is the wb_commit side.
interface wb_commit_if #(
    parameter int unsigned DATA_W = wb_commit_pkg::XLEN,
    parameter int unsigned ADDR_W = wb_commit_pkg::REG_IDX_W
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;
    logic [ADDR_W-1:0] commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic              wb_empty;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, commit_rd, commit_data, wb_empty
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, commit_rd, commit_data, wb_empty
    );
endinterface

// File: rtl/wb_commit_fifo.sv
// In-order result FIFO with two ordered enqueue slots (slot 0 ahead of slot 1)
// and a single dequeue; pointers wrap modulo DEPTH.
module wb_commit_fifo
    import wb_commit_pkg::*;
#(
    parameter  int unsigned DEPTH  = WB_DEPTH,
    parameter  int unsigned DATA_W = XLEN,
    parameter  int unsigned ADDR_W = REG_IDX_W,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              push0,
    input  logic [ADDR_W-1:0] rd0,
    input  logic [DATA_W-1:0] data0,
    input  logic              push1,
    input  logic [ADDR_W-1:0] rd1,
    input  logic [DATA_W-1:0] data1,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_rd,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  count_next
);

    logic [ADDR_W-1:0] mem_rd_r   [DEPTH];
    logic [DATA_W-1:0] mem_data_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic              wr_a_s;
    logic              wr_b_s;
    logic [ADDR_W-1:0] a_rd_s;
    logic [DATA_W-1:0] a_data_s;
    logic [CNT_W-1:0]  n_push_s;
    logic [CNT_W-1:0]  count_next_s;

    // Compact the two push slots so the first accepted result always lands at tail.
    always_comb begin
        wr_a_s   = push0 | push1;
        wr_b_s   = push0 & push1;
        n_push_s = CNT_W'(push0) + CNT_W'(push1);
        if (push0) begin
            a_rd_s   = rd0;
            a_data_s = data0;
        end else begin
            a_rd_s   = rd1;
            a_data_s = data1;
        end
        if (en) begin
            count_next_s = count_r + n_push_s - CNT_W'(pop);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers and occupancy; everything holds while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (wr_a_s) begin
                mem_rd_r[tail_r]   <= a_rd_s;
                mem_data_r[tail_r] <= a_data_s;
            end
            if (wr_b_s) begin
                mem_rd_r[tail_r + PTR_W'(1)]   <= rd1;
                mem_data_r[tail_r + PTR_W'(1)] <= data1;
            end
            tail_r  <= tail_r + PTR_W'(n_push_s);
            head_r  <= head_r + PTR_W'(pop);
            count_r <= count_next_s;
        end
    end

    assign head_rd    = mem_rd_r[head_r];
    assign head_data  = mem_data_r[head_r];
    assign count      = count_r;
    assign count_next = count_next_s;

endmodule

// File: rtl/wb_commit.sv
// Writeback producer: accepts SALU/LSU results, drops x0 writes, buffers them in
// order and drives one registered commit per cycle to the register file.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter  int unsigned DEPTH  = WB_DEPTH,
    parameter  int unsigned DATA_W = XLEN,
    parameter  int unsigned ADDR_W = REG_IDX_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    wb_commit_if.slave  bus
);

    logic [CNT_W-1:0]  count_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [ADDR_W-1:0] head_rd_s;
    logic [DATA_W-1:0] head_data_s;
    logic              alu_acc_s;
    logic              lsu_acc_s;
    logic              pop_s;
    logic [ADDR_W-1:0] commit_rd_next_s;

    logic [ADDR_W-1:0] commit_rd_r;
    logic [DATA_W-1:0] commit_data_r;
    logic              ready_r;
    logic              empty_r;

    // Acceptance uses the registered ready only; x0 results are swallowed here.
    always_comb begin
        alu_acc_s = bus.alu_valid & ready_r & rdy & (bus.alu_rd != {ADDR_W{1'b0}});
        lsu_acc_s = bus.lsu_valid & ready_r & rdy & (bus.lsu_rd != {ADDR_W{1'b0}});
        pop_s     = rdy & (count_s != {CNT_W{1'b0}});
        if (pop_s) begin
            commit_rd_next_s = head_rd_s;
        end else begin
            commit_rd_next_s = {ADDR_W{1'b0}};
        end
    end

    wb_commit_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .en         (rdy),
        .push0      (alu_acc_s),
        .rd0        (bus.alu_rd),
        .data0      (bus.alu_data),
        .push1      (lsu_acc_s),
        .rd1        (bus.lsu_rd),
        .data1      (bus.lsu_data),
        .pop        (pop_s),
        .head_rd    (head_rd_s),
        .head_data  (head_data_s),
        .count      (count_s),
        .count_next (count_next_s)
    );

    // Commit port plus ready/empty flags, all computed from next-state occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_rd_r   <= {ADDR_W{1'b0}};
            commit_data_r <= {DATA_W{1'b0}};
            ready_r       <= 1'b1;
            empty_r       <= 1'b1;
        end else if (rdy) begin
            commit_rd_r <= commit_rd_next_s;
            if (pop_s) begin
                commit_data_r <= head_data_s;
            end
            ready_r <= has_two_free(DEPTH, 32'(count_next_s));
            empty_r <= (count_next_s == {CNT_W{1'b0}}) && (commit_rd_next_s == {ADDR_W{1'b0}});
        end
    end

    assign bus.alu_ready   = ready_r;
    assign bus.lsu_ready   = ready_r;
    assign bus.commit_rd   = commit_rd_r;
    assign bus.commit_data = commit_data_r;
    assign bus.wb_empty    = empty_r;

endmodule

// File: tb/tb_wb_commit.sv
// Directed and randomized bench for wb_commit against a queue-based model
// of the in-order writeback buffer.
module tb_wb_commit;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;
    logic rdy;
    int   checks;
    int   errors;

    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    logic [4:0]  m_crd;
    logic [31:0] m_cdata;

    wb_commit_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_commit #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare just after it.
    task automatic step(input string tag, input logic r, input logic en,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        logic ready_pre;
        logic exp_ready;
        rst           = r;
        rdy           = en;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;
        ready_pre = ((DEPTH - q_rd.size()) >= 2);
        @(posedge clk);
        if (r) begin
            q_rd.delete();
            q_data.delete();
            m_crd   = 5'd0;
            m_cdata = 32'd0;
        end else if (en) begin
            if (q_rd.size() > 0) begin
                m_crd   = q_rd.pop_front();
                m_cdata = q_data.pop_front();
            end else begin
                m_crd = 5'd0;
            end
            if (av && ready_pre && ard != 5'd0) begin
                q_rd.push_back(ard);
                q_data.push_back(ad);
            end
            if (lv && ready_pre && lrd != 5'd0) begin
                q_rd.push_back(lrd);
                q_data.push_back(ld);
            end
        end
        exp_ready = ((DEPTH - q_rd.size()) >= 2);
        #1;
        chk({tag, ".commit_rd"},   32'(bus.commit_rd), 32'(m_crd));
        chk({tag, ".commit_data"}, bus.commit_data,    m_cdata);
        chk({tag, ".alu_ready"},   32'(bus.alu_ready), 32'(exp_ready));
        chk({tag, ".lsu_ready"},   32'(bus.lsu_ready), 32'(exp_ready));
        chk({tag, ".wb_empty"},    32'(bus.wb_empty),
            32'((q_rd.size() == 0) && (m_crd == 5'd0)));
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        end
    endtask

    initial begin
        clk = 1'b0;
        checks = 0;
        errors = 0;
        m_crd = 5'd0;
        m_cdata = 32'd0;
        rst = 1'b1;
        rdy = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
        @(negedge clk);

        step("reset", 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Single SALU result: committed the next cycle, then back to empty.
        step("alu5", 1'b0, 1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        chk("alu5.fixed_rd_after_accept", 32'(bus.commit_rd), 32'd0);
        idle("alu5_drain", 1);
        chk("alu5.fixed_rd", 32'(bus.commit_rd), 32'd5);
        chk("alu5.fixed_data", bus.commit_data, 32'h11);
        idle("alu5_after", 1);
        chk("alu5.fixed_empty", 32'(bus.wb_empty), 32'd1);

        // Same-cycle pair: SALU ahead of LSU.
        step("pair", 1'b0, 1'b1, 1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
        idle("pair_drain", 1);
        chk("pair.first_rd", 32'(bus.commit_rd), 32'd3);
        idle("pair_drain", 1);
        chk("pair.second_rd", 32'(bus.commit_rd), 32'd4);
        chk("pair.second_data", bus.commit_data, 32'hB);
        idle("pair_drain", 2);

        // x0 result is dropped.
        step("x0", 1'b0, 1'b1, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
        idle("x0_after", 3);

        // Back-to-back pairs fill the FIFO and drop the readies.
        for (int i = 0; i < 4; i++) begin
            step("fill", 1'b0, 1'b1, 1'b1, 5'(8 + 2 * i), 32'(100 + i), 1'b1, 5'(9 + 2 * i), 32'(200 + i));
        end
        idle("fill_drain", 6);

        // Stall with two queued entries.
        step("stall_load", 1'b0, 1'b1, 1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
        idle("stall_pre", 1);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b0, 1'b0, 1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
        end
        idle("stall_resume", 3);

        // Reset discards queued entries.
        step("rst_load", 1'b0, 1'b1, 1'b1, 5'd24, 32'h24, 1'b1, 5'd25, 32'h25);
        step("rst_load", 1'b0, 1'b1, 1'b1, 5'd26, 32'h26, 1'b1, 5'd27, 32'h27);
        step("rst_mid", 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("rst_mid.fixed_empty", 32'(bus.wb_empty), 32'd1);
        idle("rst_after", 4);

        // Randomized traffic, including protocol-error valids and occasional stall/reset.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(59, 0) == 0), ($urandom_range(7, 0) != 0),
                 $urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)), $urandom(),
                 $urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)), $urandom());
        end
        idle("final_drain", 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
